// File: rtl/hello_scroller.sv
// Rotating "HELLO   " source for the eight-digit display.
// Emits one 3-bit character code per digit and advances on a prescaled tick or on a manual key step.
module hello_scroller #(
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned CNT_W    = 25
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        run,
   input  logic        dir,
   input  logic        step,
   output logic [23:0] chars,
   output logic [2:0]  pos,
   output logic        shift
);

   localparam logic [2:0] CODE_H     = 3'b000;
   localparam logic [2:0] CODE_E     = 3'b001;
   localparam logic [2:0] CODE_O     = 3'b010;
   localparam logic [2:0] CODE_L     = 3'b011;
   localparam logic [2:0] CODE_BLANK = 3'b111;

   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

   typedef enum logic {
      PAUSED,
      RUNNING
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [2:0]       pos_next;
   logic             step_q;
   logic             step_rise;
   logic             advance;

   // Fixed message: slots 0..7 = H E L L O blank blank blank
   function automatic logic [2:0] msg_code(input logic [2:0] slot);
      logic [2:0] code;
      case (slot)
         3'd0:    code = CODE_H;
         3'd1:    code = CODE_E;
         3'd2:    code = CODE_L;
         3'd3:    code = CODE_L;
         3'd4:    code = CODE_O;
         default: code = CODE_BLANK;
      endcase
      return code;
   endfunction

   assign step_rise = step & ~step_q;

   // step_q resets high so a key held through reset never counts as a fresh press
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state  <= PAUSED;
         cnt    <= '0;
         pos    <= 3'd0;
         shift  <= 1'b0;
         step_q <= 1'b1;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         pos    <= pos_next;
         shift  <= advance;
         step_q <= step;
      end
   end

   // Any change of run restarts the prescaler from zero; leaving RUNNING never advances
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      advance    = 1'b0;
      case (state)
         PAUSED: begin
            cnt_next = '0;
            if (run) begin
               state_next = RUNNING;
            end else if (step_rise) begin
               advance = 1'b1;
            end
         end
         RUNNING: begin
            if (!run) begin
               state_next = PAUSED;
               cnt_next   = '0;
            end else if (cnt == CNT_TERM) begin
               advance  = 1'b1;
               cnt_next = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = PAUSED;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      pos_next = pos;
      if (advance) begin
         pos_next = dir ? (pos - 3'd1) : (pos + 3'd1);
      end
   end

   // HEXk shows slot (7-k+pos) mod 8; 3-bit arithmetic gives the wrap for free
   always_comb begin
      chars = '0;
      for (int k = 0; k < 8; k++) begin
         chars[3*k +: 3] = msg_code(3'(7 - k) + pos);
      end
   end

endmodule
